// File: rtl/spi_eep_responder_if.sv
// SPI bus bundle shared by the DSO SPI master and the calibration EEPROM responder.
interface spi_eep_responder_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_eep_responder.sv
// SPI mode-0 slave modelling the 64x8 calibration EEPROM: 16-bit write/read frames.
// Define MISO_TRISTATE_EN to float MISO when deselected; otherwise MISO is forced low.
module spi_eep_responder #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FRAME_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_eep_responder_if.slave spi,
    output logic               wrt_done,
    output logic               rd_done,
    output logic               frame_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    logic [2:0] ss_q, sclk_q, fill_q;
    logic [1:0] mosi_q;
    logic       sync_ok, ss_lvl, ss_rise, sclk_rise, sclk_fall, mosi_s;

    // fill_q marks when the whole sync chain holds sampled data rather than reset values,
    // so a select held low across reset release never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= '1;
            sclk_q <= '0;
            mosi_q <= '0;
            fill_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[0], spi.MOSI};
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    assign sync_ok   = fill_q[2];
    assign ss_lvl    = ss_q[1];
    assign ss_rise   = sync_ok & ss_q[1] & ~ss_q[2];
    assign sclk_rise = sync_ok & sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = sync_ok & ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];

    state_e                          state_q, state_d;
    logic [FRAME_BITS-1:0]           rx_q, rx_d, tx_q, tx_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DATA_W-1:0]               stage_q, stage_d;
    logic                            armed_q, armed_d;
    logic                            wrt_q, wrt_d, rd_q, rd_d, err_q, err_d;
    logic                            mem_we;
    logic [DEPTH-1:0][DATA_W-1:0]    mem_q;

    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    assign op    = rx_q[FRAME_BITS-1 -: 2];
    assign addr  = rx_q[DATA_W +: ADDR_W];
    assign wdata = rx_q[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rx_q    <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            armed_q <= 1'b0;
            wrt_q   <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            armed_q <= armed_d;
            wrt_q   <= wrt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Start is level-based on the synchronised select once it has been seen high,
    // so a select fall that lands during COMMIT is picked up in the next IDLE cycle.
    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        armed_d = armed_q | (sync_ok & ss_lvl);
        wrt_d   = 1'b0;
        rd_d    = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed_q && !ss_lvl) begin
                    state_d = SHIFT;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = FRAME_BITS'(stage_q);
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        rx_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                        if (cnt_q != CNT_W'(FRAME_BITS + 1))
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (sclk_fall)
                        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            COMMIT: begin
                state_d = IDLE;
                case (op)
                    2'b01: begin
                        mem_we  = 1'b1;
                        wrt_d   = 1'b1;
                        tx_d    = '0;
                        stage_d = '0;
                    end
                    2'b00: begin
                        rd_d    = 1'b1;
                        tx_d    = FRAME_BITS'(mem_q[addr]);
                        stage_d = mem_q[addr];
                    end
                    default: begin
                        tx_d    = '0;
                        stage_d = '0;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '0;
        else if (mem_we)
            mem_q[addr] <= wdata;
    end

    assign wrt_done  = wrt_q;
    assign rd_done   = rd_q;
    assign frame_err = err_q;

`ifdef MISO_TRISTATE_EN
    assign spi.MISO = (!rst_n || ss_lvl) ? 1'bz : tx_q[FRAME_BITS-1];
`else
    assign spi.MISO = (rst_n && !ss_lvl) ? tx_q[FRAME_BITS-1] : 1'b0;
`endif
endmodule

// File: doc/spi_eep_responder.md
Name: spi_eep_responder

Overview:
- SPI slave that implements the calibration EEPROM end of the DSO SPI bus.
- Responds to 16-bit frames from the SPI master: write frames update on-chip storage; read frames return the stored byte during the following frame.
- Holds 64x8 storage.
- Sits on the shared MOSI/SCLK/MISO bus, selected by EEP_ss_n. Also serves as the synthesizable EEPROM model for full-chip benches.

Parameters:
- ADDR_W, 6, address width; storage depth is 2**ADDR_W.
- DATA_W, 8, data byte width.
- FRAME_BITS, 16, bits per frame; must equal 2+ADDR_W+DATA_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- SS_n  input  1  slave select, active-low, asynchronous to clk.
- SCLK  input  1  SPI clock, idles low (mode 0), asynchronous to clk; clk >= 8x SCLK.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- wrt_done  output  1  1-clk pulse when a write frame commits.
- rd_done  output  1  1-clk pulse when a read frame commits (read data staged).
- frame_err  output  1  1-clk pulse when a frame aborts (bit count != FRAME_BITS).

Behaviour:
- Clock decided: clock clk; reset rst_n, asynchronous, active-low.
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a third flop for edge detection on SS_n and SCLK.
  - All internal logic uses the synchronised versions.
  - SCLK rise/fall and SS_n fall/rise are 1-clk detect pulses.
- Frame format, MSB first:
  - [15:14] op: 01 = write, 00 = read, 1x = ignored.
  - [13:8] address.
  - [7:0] data; don't-care for read.
- rx_shift (16b): on each SCLK rise while selected, shift left and load synchronised MOSI into bit 0.
- tx_shift (16b):
  - On each SCLK fall while selected, shift left and fill bit 0 with 0.
  - MISO = tx_shift[15] while selected, so the first bit is valid before the first SCLK rise.
- bit_cnt (5b): cleared on SS_n fall; increments on SCLK rise; saturates at FRAME_BITS+1.
- State machine:
  - IDLE: wait for SS_n fall; then clear bit_cnt and go to SHIFT.
  - SHIFT: shift on SCLK edges.
    - On SS_n rise with bit_cnt == FRAME_BITS, go to COMMIT.
    - On SS_n rise with any other count, pulse frame_err, discard rx_shift, leave tx_shift unchanged, and go to IDLE.
  - COMMIT (exactly 1 clk), decode rx_shift, then go to IDLE:
    - op 01: mem[addr] <= data; pulse wrt_done; tx_shift <= 0.
    - op 00: tx_shift <= {8'h00, mem[addr]}; pulse rd_done.
    - op 1x: no write, no pulse; tx_shift <= 0.
- Latency: write visible in mem, and wrt_done asserted, 4 clk after the raw SS_n rising edge (2 sync + 1 edge + COMMIT).
- Read data: returned only on the immediately following frame.
  - An aborted frame in between does not clear the staged read data.
  - Any committed frame replaces it.
- Simultaneous events:
  - An SS_n fall detected in COMMIT is honoured in the next IDLE cycle; the synchronised level is sampled, so no edge is lost.
  - SCLK edges while deselected are ignored.
- Back-to-back: a read of an address written by the previous frame returns the new data.
- Reset (including mid-frame):
  - state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=0, all mem entries=8'h00.
  - wrt_done=rd_done=frame_err=0.
  - MISO per the optional-feature rule.
  - After reset release, a partial frame in progress is not committed: the first SS_n rise counts as abort only if an SS_n fall was seen.

Optional Feature:
- Macro MISO_TRISTATE_EN.
- Defined: MISO = 1'bz whenever synchronised SS_n is high or rst_n is low, allowing a shared MISO line.
- Undefined: MISO = 1'b0 when deselected or in reset; the top level ORs the slave MISO lines.
- Selected-state behaviour is identical in both builds.

Test Plan:
- Reset, then frame 16'h5CEF -> wrt_done pulse 4 clk after SS_n rise; mem[0x1C]=8'hEF; MISO shifted out 16'h0000.
- After the write, frame 16'h1C00 then frame 16'h0000 -> rd_done pulse after the first frame; master captures 16'h00EF on MISO during the second frame.
- Frame 16'h5C12, SS_n raised after 10 SCLK edges -> frame_err pulse; mem[0x1C] still 8'hEF; no wrt_done.
- Frame 16'hDC55 (op 11) -> no wrt_done/rd_done/frame_err; mem unchanged; next frame MISO returns 16'h0000.
- rst_n asserted after 8 bits of frame 16'h4AAA -> all outputs 0 immediately, mem[0x0A]=8'h00; next full frame 16'h4A3C writes 8'h3C.
- Build with MISO_TRISTATE_EN -> MISO=z while SS_n high, driven while SS_n low. Build without -> MISO=0 while SS_n high.
